// File: rtl/hanoi_if.sv
// Move/response interface for the Tower-of-Hanoi engine.
// Parameters: DISCS (number of discs), PEGS (number of pegs).
// Signals:
//   mv_valid/mv_ready    move request handshake
//   mv_from/mv_to        source/destination peg index (PW bits)
//   rsp_valid/rsp_code   one-cycle response; 0 OK, 1 bad peg, 2 source empty, 3 larger-on-smaller
//   peg_cnt/top_disc     flattened per-peg disc count and top disc id (CW bits per peg)
//   solved               all discs on the last peg
//   move_cnt/err_cnt     statistics counters (zero when statistics are compiled out)
// Modports: master drives requests, slave is the engine.
interface hanoi_if #(
    parameter int unsigned DISCS = 4,
    parameter int unsigned PEGS  = 3
);
    localparam int unsigned PW = $clog2(PEGS);
    localparam int unsigned CW = $clog2(DISCS + 1);

    logic               mv_valid;
    logic               mv_ready;
    logic [PW-1:0]      mv_from;
    logic [PW-1:0]      mv_to;
    logic               rsp_valid;
    logic [1:0]         rsp_code;
    logic [PEGS*CW-1:0] peg_cnt;
    logic [PEGS*CW-1:0] top_disc;
    logic               solved;
    logic [15:0]        move_cnt;
    logic [15:0]        err_cnt;

    modport master (
        output mv_valid, mv_from, mv_to,
        input  mv_ready, rsp_valid, rsp_code, peg_cnt, top_disc, solved, move_cnt, err_cnt
    );

    modport slave (
        input  mv_valid, mv_from, mv_to,
        output mv_ready, rsp_valid, rsp_code, peg_cnt, top_disc, solved, move_cnt, err_cnt
    );
endinterface

// File: rtl/hanoi_engine.sv
// Tower-of-Hanoi state engine. Holds a DISCS-disc, PEGS-peg puzzle in registers,
// accepts one move at a time, checks it against the puzzle rules, commits legal moves
// and answers each move with a one-cycle response carrying an error code.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   hanoi_if.slave: move handshake, response, per-peg status, solved, statistics
// Optional feature: define HANOI_STATS_EN to build saturating 16-bit move_cnt/err_cnt
// counters; otherwise both outputs are tied to zero and no counter flops exist.
module hanoi_engine #(
    parameter int unsigned DISCS = 4,
    parameter int unsigned PEGS  = 3
) (
    input logic    clk,
    input logic    rst,
    hanoi_if.slave bus
);
    localparam int unsigned PW = $clog2(PEGS);
    localparam int unsigned CW = $clog2(DISCS + 1);

    typedef enum logic [1:0] {StIdle, StCheck, StCommit} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] from_q, from_d;
    logic [PW-1:0] to_q, to_d;
    logic [1:0]    code_q, code_d;

    logic [CW-1:0] cnt_q   [PEGS];
    logic [CW-1:0] cnt_d   [PEGS];
    logic [CW-1:0] stack_q [PEGS][DISCS];
    logic [CW-1:0] stack_d [PEGS][DISCS];

    logic [CW-1:0] top      [PEGS];
    logic [CW-1:0] cnt_from;
    logic [CW-1:0] top_from;
    logic [CW-1:0] top_to;
    logic          peg_bad;

    // Top disc per peg; constant slot indices keep the select in range for any count.
    always_comb begin
        for (int p = 0; p < PEGS; p++) begin
            top[p] = '0;
            for (int s = 0; s < DISCS; s++) begin
                if (cnt_q[p] == CW'(s + 1)) top[p] = stack_q[p][s];
            end
        end
    end

    // Operand select by decode so an out-of-range peg index never addresses the arrays.
    always_comb begin
        cnt_from = '0;
        top_from = '0;
        top_to   = '0;
        for (int p = 0; p < PEGS; p++) begin
            if (from_q == PW'(p)) begin
                cnt_from = cnt_q[p];
                top_from = top[p];
            end
            if (to_q == PW'(p)) top_to = top[p];
        end
    end

    assign peg_bad = (32'(from_q) >= PEGS) || (32'(to_q) >= PEGS) || (from_q == to_q);

    always_comb begin
        state_d       = state_q;
        from_d        = from_q;
        to_d          = to_q;
        code_d        = code_q;
        cnt_d         = cnt_q;
        stack_d       = stack_q;
        bus.mv_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_code  = 2'd0;
        unique case (state_q)
            StIdle: begin
                bus.mv_ready = 1'b1;
                if (bus.mv_valid) begin
                    from_d  = bus.mv_from;
                    to_d    = bus.mv_to;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (peg_bad) begin
                    code_d = 2'd1;
                end else if (cnt_from == '0) begin
                    code_d = 2'd2;
                end else if ((top_to != '0) && (top_from > top_to)) begin
                    code_d = 2'd3;
                end else begin
                    code_d = 2'd0;
                end
                state_d = StCommit;
            end
            StCommit: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_code  = code_q;
                if (code_q == 2'd0) begin
                    for (int p = 0; p < PEGS; p++) begin
                        if (from_q == PW'(p)) cnt_d[p] = cnt_q[p] - CW'(1);
                        if (to_q == PW'(p)) begin
                            for (int s = 0; s < DISCS; s++) begin
                                if (cnt_q[p] == CW'(s)) stack_d[p][s] = top_from;
                            end
                            cnt_d[p] = cnt_q[p] + CW'(1);
                        end
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            from_q  <= '0;
            to_q    <= '0;
            code_q  <= 2'd0;
            for (int p = 0; p < PEGS; p++) begin
                cnt_q[p] <= (p == 0) ? CW'(DISCS) : '0;
                for (int s = 0; s < DISCS; s++) begin
                    stack_q[p][s] <= (p == 0) ? CW'(DISCS - s) : '0;
                end
            end
        end else begin
            state_q <= state_d;
            from_q  <= from_d;
            to_q    <= to_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            stack_q <= stack_d;
        end
    end

    always_comb begin
        bus.peg_cnt  = '0;
        bus.top_disc = '0;
        for (int p = 0; p < PEGS; p++) begin
            bus.peg_cnt[p*CW +: CW]  = cnt_q[p];
            bus.top_disc[p*CW +: CW] = top[p];
        end
    end

    assign bus.solved = (cnt_q[PEGS-1] == CW'(DISCS));

`ifdef HANOI_STATS_EN
    logic [15:0] move_cnt_q;
    logic [15:0] err_cnt_q;

    // Saturating counters, updated on the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (state_q == StCommit) begin
            if (code_q == 2'd0) begin
                if (move_cnt_q != 16'hFFFF) move_cnt_q <= move_cnt_q + 16'd1;
            end else begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign bus.move_cnt = move_cnt_q;
    assign bus.err_cnt  = err_cnt_q;
`else
    assign bus.move_cnt = '0;
    assign bus.err_cnt  = '0;
`endif

endmodule

// File: tb/tb_hanoi_engine.sv
// Directed testbench for hanoi_engine (DISCS=4, PEGS=3). Drives moves through hanoi_if,
// checks response codes, latency, per-peg status, solved, statistics and invariants.
module tb_hanoi_engine;
    localparam int unsigned DISCS = 4;
    localparam int unsigned PEGS  = 3;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;
    logic prev_rsp = 0;

    hanoi_if #(.DISCS(DISCS), .PEGS(PEGS)) bus ();

    hanoi_engine #(.DISCS(DISCS), .PEGS(PEGS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Invariants sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int sum;
            bit ordered;
            sum = 0;
            ordered = 1;
            for (int p = 0; p < PEGS; p++) begin
                int c;
                c = int'(bus.peg_cnt[p*3 +: 3]);
                sum += c;
                for (int s = 1; s < DISCS; s++) begin
                    if (s < c && u_dut.stack_q[p][s] >= u_dut.stack_q[p][s-1]) ordered = 0;
                end
            end
            check_eq("inv_sum", sum, DISCS);
            check_eq("inv_order", ordered, 1);
            check_eq("inv_rsp_pulse", prev_rsp & bus.rsp_valid, 0);
            prev_rsp = bus.rsp_valid;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a falling edge with the engine idle; returns on a falling edge, idle again.
    task automatic do_move(input int f, input int t, input logic [1:0] exp_code, input string tag);
        int   lat;
        bit   got;
        logic [1:0] code;
        check_eq({tag, "_ready"}, bus.mv_ready, 1);
        bus.mv_from  = f[1:0];
        bus.mv_to    = t[1:0];
        bus.mv_valid = 1'b1;
        @(posedge clk);
        #1 bus.mv_valid = 1'b0;
        lat  = 0;
        got  = 0;
        code = 2'd0;
        while (lat < 6 && !got) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                got  = 1;
                code = bus.rsp_code;
            end
        end
        check_eq({tag, "_rsp_seen"}, got, 1);
        check_eq({tag, "_latency"}, lat, 2);
        check_eq({tag, "_code"}, code, exp_code);
        @(negedge clk);
    endtask

    int mv_f [15] = '{0, 0, 1, 0, 2, 2, 0, 0, 1, 1, 2, 1, 0, 0, 1};
    int mv_t [15] = '{1, 2, 2, 1, 0, 1, 1, 2, 2, 0, 0, 2, 1, 2, 2};

    initial begin
        int acc;
        int rsp;
        int last;
        rst          = 1'b1;
        bus.mv_valid = 1'b0;
        bus.mv_from  = '0;
        bus.mv_to    = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1;

        // Reset configuration
        check_eq("rst_peg_cnt", bus.peg_cnt, {3'd0, 3'd0, 3'd4});
        check_eq("rst_top_disc", bus.top_disc, {3'd0, 3'd0, 3'd1});
        check_eq("rst_solved", bus.solved, 0);
        check_eq("rst_ready", bus.mv_ready, 1);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_code", bus.rsp_code, 0);
        check_eq("rst_move_cnt", bus.move_cnt, 0);
        check_eq("rst_err_cnt", bus.err_cnt, 0);

        // Legal move of the smallest disc
        do_move(0, 2, 2'd0, "m02");
        check_eq("m02_peg_cnt", bus.peg_cnt, {3'd1, 3'd0, 3'd3});
        check_eq("m02_top_disc", bus.top_disc, {3'd1, 3'd0, 3'd2});

        // Legal move, then larger-on-smaller rejection
        do_move(0, 1, 2'd0, "m01");
        check_eq("m01_peg_cnt", bus.peg_cnt, {3'd1, 3'd1, 3'd2});
        check_eq("m01_top_disc", bus.top_disc, {3'd1, 3'd2, 3'd3});
        do_move(1, 2, 2'd3, "m12_big");
        check_eq("m12_peg_cnt", bus.peg_cnt, {3'd1, 3'd1, 3'd2});
        check_eq("m12_top_disc", bus.top_disc, {3'd1, 3'd2, 3'd3});

        // Bad peg and empty source
        do_reset();
        do_move(1, 1, 2'd1, "same_peg");
        do_move(3, 0, 2'd1, "from_oob");
        do_move(0, 3, 2'd1, "to_oob");
        do_move(1, 2, 2'd2, "empty_src");
        do_move(2, 0, 2'd2, "empty_src2");
        check_eq("rej_peg_cnt", bus.peg_cnt, {3'd0, 3'd0, 3'd4});
        check_eq("rej_top_disc", bus.top_disc, {3'd0, 3'd0, 3'd1});

        // Optimal 15-move solution
        do_reset();
        for (int i = 0; i < 15; i++) begin
            if (i == 14) check_eq("pre_solved", bus.solved, 0);
            do_move(mv_f[i], mv_t[i], 2'd0, $sformatf("opt%0d", i));
        end
        check_eq("opt_solved", bus.solved, 1);
        check_eq("opt_peg_cnt", bus.peg_cnt, {3'd4, 3'd0, 3'd0});
        check_eq("opt_top_disc", bus.top_disc, {3'd1, 3'd0, 3'd0});
`ifdef HANOI_STATS_EN
        check_eq("opt_move_cnt", bus.move_cnt, 15);
`else
        check_eq("opt_move_cnt", bus.move_cnt, 0);
`endif
        check_eq("opt_err_cnt", bus.err_cnt, 0);
        do_move(2, 0, 2'd0, "undo");
        check_eq("undo_solved", bus.solved, 0);

        // Back-to-back: mv_valid held high
        do_reset();
        bus.mv_from  = 2'd0;
        bus.mv_to    = 2'd1;
        bus.mv_valid = 1'b1;
        acc  = 0;
        rsp  = 0;
        last = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.mv_ready && bus.mv_valid) begin
                if (acc > 0) check_eq("b2b_gap", i - last, 3);
                last = i;
                acc++;
            end
            if (bus.rsp_valid) rsp++;
            @(negedge clk);
        end
        check_eq("b2b_accepts", acc, 4);
        check_eq("b2b_rsps", rsp, 4);
        check_eq("b2b_peg_cnt", bus.peg_cnt, {3'd0, 3'd1, 3'd3});

        // Reset during CHECK aborts the move
        bus.mv_from = 2'd0;
        bus.mv_to   = 2'd2;
        check_eq("abort_ready", bus.mv_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.mv_valid = 1'b0;
        rst          = 1'b1;
        check_eq("abort_in_check", bus.mv_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_rsp0", bus.rsp_valid, 0);
        check_eq("abort_peg_cnt", bus.peg_cnt, {3'd0, 3'd0, 3'd4});
        check_eq("abort_top_disc", bus.top_disc, {3'd0, 3'd0, 3'd1});
        check_eq("abort_ready2", bus.mv_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_rsp", bus.rsp_valid, 0);
        end
        check_eq("abort_final_cnt", bus.peg_cnt, {3'd0, 3'd0, 3'd4});

        mon_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
